// File: rtl/vram_pkg.sv
// Shared constants and types for the text-mode VRAM write path.
package vram_pkg;

    localparam int unsigned CELLS  = 2000;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] FILL_WORD = 16'h0700;
    localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic {
        CLEAR,
        ARB
    } state_e;

    typedef enum logic {
        GRANT_CPU,
        GRANT_CON
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Request, grant and VRAM write-port signals shared by the arbiter and its clients.
interface vram_write_arbiter_if;
    import vram_pkg::*;

    logic              clear_req;
    logic              clear_busy;
    logic              cpu_valid;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              con_valid;
    logic              con_ready;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_data;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;
    logic              vram_we;

    modport master (
        output clear_req, cpu_valid, cpu_addr, cpu_data,
               con_valid, con_addr, con_data,
        input  clear_busy, cpu_ready, con_ready,
               vram_addr, vram_data, vram_we
    );

    modport slave (
        input  clear_req, cpu_valid, cpu_addr, cpu_data,
               con_valid, con_addr, con_data,
        output clear_busy, cpu_ready, con_ready,
               vram_addr, vram_data, vram_we
    );

endinterface

// File: rtl/vram_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not win last gets the grant.
module rr_arb2
    import vram_pkg::*;
(
    input  logic   en,
    input  logic   req_cpu,
    input  logic   req_con,
    input  grant_e last_grant,
    output logic   gnt_cpu_c,
    output logic   gnt_con_c,
    output grant_e winner_c
);

    always_comb begin
        gnt_cpu_c = 1'b0;
        gnt_con_c = 1'b0;
        winner_c  = last_grant;
        if (en) begin
            if (req_cpu && (!req_con || last_grant == GRANT_CON)) begin
                gnt_cpu_c = 1'b1;
                winner_c  = GRANT_CPU;
            end else if (req_con) begin
                gnt_con_c = 1'b1;
                winner_c  = GRANT_CON;
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Single VRAM write port shared between the clear engine, CPU stores and console writes.
module vram_write_arbiter
    import vram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    vram_write_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    grant_e            lg_q, lg_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;

    logic              arb_en_c;
    logic              gnt_cpu_c;
    logic              gnt_con_c;
    grant_e            winner_c;
    wr_req_t           cpu_req_c;
    wr_req_t           con_req_c;
    wr_req_t           win_req_c;

    // A pending clear request pre-empts any grant in the same cycle.
    assign arb_en_c  = (state_q == ARB) && !bus.clear_req;
    assign cpu_req_c = '{addr: bus.cpu_addr, data: bus.cpu_data};
    assign con_req_c = '{addr: bus.con_addr, data: bus.con_data};
    assign win_req_c = (winner_c == GRANT_CPU) ? cpu_req_c : con_req_c;

    rr_arb2 u_rr_arb2 (
        .en         (arb_en_c),
        .req_cpu    (bus.cpu_valid),
        .req_con    (bus.con_valid),
        .last_grant (lg_q),
        .gnt_cpu_c  (gnt_cpu_c),
        .gnt_con_c  (gnt_con_c),
        .winner_c   (winner_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            lg_q    <= GRANT_CON;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            CLEAR: begin
                addr_d = cnt_q;
                data_d = FILL_WORD;
                we_d   = 1'b1;
                if (cnt_q == LAST_CELL) begin
                    cnt_d   = '0;
                    state_d = ARB;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ARB: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else if (gnt_cpu_c || gnt_con_c) begin
                    // Out-of-range addresses are accepted but never reach the RAM.
                    lg_d   = winner_c;
                    addr_d = win_req_c.addr;
                    data_d = win_req_c.data;
                    we_d   = (win_req_c.addr < CELLS_A);
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign bus.vram_addr  = addr_q;
    assign bus.vram_data  = data_q;
    assign bus.vram_we    = we_q;
    assign bus.clear_busy = busy_q;
    assign bus.cpu_ready  = gnt_cpu_c;
    assign bus.con_ready  = gnt_con_c;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: stimulus queues expected writes, a monitor checks the VRAM port.
module tb_vram_write_arbiter;
    import vram_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    vram_write_arbiter_if bus();

    vram_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic b);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < int'(CELLS); i++)
            push_exp(ADDR_W'(i), FILL_WORD, (i != int'(CELLS) - 1));
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Presents one request and holds it until accepted; returns the cycles spent waiting.
    task automatic send(input bit is_cpu, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit expect_write, output int waited);
        logic rdy;
        @(posedge clk) #1;
        if (is_cpu) begin
            bus.cpu_valid = 1'b1; bus.cpu_addr = a; bus.cpu_data = d;
        end else begin
            bus.con_valid = 1'b1; bus.con_addr = a; bus.con_data = d;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            rdy = is_cpu ? bus.cpu_ready : bus.con_ready;
            if (rdy) break;
            waited++;
            if (waited > 3000) break;
        end
        if (rdy && expect_write) push_exp(a, d, 1'b0);
        @(posedge clk) #1;
        bus.cpu_valid = 1'b0;
        bus.con_valid = 1'b0;
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (bus.clear_busy) begin
                n_vec++;
                if (bus.cpu_ready || bus.con_ready) begin
                    n_err++;
                    $display("FAIL ready_during_clear: got cpu=%b con=%b, required 0 0",
                             bus.cpu_ready, bus.con_ready);
                end
            end
            if (bus.vram_we) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                             bus.vram_addr, bus.vram_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.vram_addr !== e.addr || bus.vram_data !== e.data || bus.clear_busy !== e.busy) begin
                        n_err++;
                        $display("FAIL vram_write: got addr %0d data %h busy %b, required addr %0d data %h busy %b",
                                 bus.vram_addr, bus.vram_data, bus.clear_busy, e.addr, e.data, e.busy);
                    end
                end
            end
        end
    end

    initial begin
        int  w;
        int  stray;
        bit  found;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.clear_req = 1'b0;
        bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.con_valid = 1'b0; bus.con_addr = '0; bus.con_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",    32'(bus.vram_we),    32'd0);
        check("rst_busy",  32'(bus.clear_busy), 32'd1);
        check("rst_addr",  32'(bus.vram_addr),  32'd0);
        check("rst_data",  32'(bus.vram_data),  32'd0);
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_con_ready", 32'(bus.con_ready), 32'd0);

        // Initial clear: 2000 fill writes
        push_clear();
        @(posedge clk) #1 rst = 1'b1;
        wait_drain(2100);
        check("busy_after_clear", 32'(bus.clear_busy), 32'd0);

        // Both requesters held: CPU, CON, CPU, CON, CPU
        @(posedge clk) #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 12'd10; bus.cpu_data = 16'h0741;
        bus.con_valid = 1'b1; bus.con_addr = 12'd11; bus.con_data = 16'h0742;
        @(negedge clk);
        check("rr0_cpu", 32'(bus.cpu_ready), 32'd1);
        check("rr0_con", 32'(bus.con_ready), 32'd0);
        push_exp(12'd10, 16'h0741, 1'b0);
        @(posedge clk) #1; bus.cpu_addr = 12'd12; bus.cpu_data = 16'h0743;
        @(negedge clk);
        check("rr1_cpu", 32'(bus.cpu_ready), 32'd0);
        check("rr1_con", 32'(bus.con_ready), 32'd1);
        push_exp(12'd11, 16'h0742, 1'b0);
        @(posedge clk) #1; bus.con_addr = 12'd13; bus.con_data = 16'h0744;
        @(negedge clk);
        check("rr2_cpu", 32'(bus.cpu_ready), 32'd1);
        check("rr2_con", 32'(bus.con_ready), 32'd0);
        push_exp(12'd12, 16'h0743, 1'b0);
        @(posedge clk) #1; bus.cpu_addr = 12'd14; bus.cpu_data = 16'h0745;
        @(negedge clk);
        check("rr3_cpu", 32'(bus.cpu_ready), 32'd0);
        check("rr3_con", 32'(bus.con_ready), 32'd1);
        push_exp(12'd13, 16'h0744, 1'b0);
        @(posedge clk) #1; bus.con_valid = 1'b0;
        @(negedge clk);
        check("rr4_cpu", 32'(bus.cpu_ready), 32'd1);
        push_exp(12'd14, 16'h0745, 1'b0);
        @(posedge clk) #1; bus.cpu_valid = 1'b0;
        wait_drain(10);

        // Single CPU write, latency 1, then idle
        send(1'b1, 12'd5, 16'h0748, 1'b1, w);
        check("cpu_wait", 32'(w), 32'd0);
        @(posedge clk) #1;
        check("cpu_we_after", 32'(bus.vram_we), 32'd0);
        check("cpu_hold_addr", 32'(bus.vram_addr), 32'd5);

        // Out-of-range console write is accepted but dropped
        send(1'b0, 12'd2000, 16'h0741, 1'b0, w);
        check("oor_wait", 32'(w), 32'd0);
        check("oor_we", 32'(bus.vram_we), 32'd0);
        send(1'b0, 12'd1999, 16'h0749, 1'b1, w);
        check("last_cell_wait", 32'(w), 32'd0);
        wait_drain(10);

        // clear_req beats a held CPU request; a second pulse mid-clear is ignored
        @(posedge clk) #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 12'd20; bus.cpu_data = 16'h0755;
        bus.clear_req = 1'b1;
        @(negedge clk);
        check("clear_wins", 32'(bus.cpu_ready), 32'd0);
        push_clear();
        @(posedge clk) #1 bus.clear_req = 1'b0;
        stray = 0;
        for (int k = 1; k <= int'(CELLS); k++) begin
            if (k == 500) bus.clear_req = 1'b1;
            @(negedge clk);
            if (bus.cpu_ready) stray++;
            @(posedge clk) #1 bus.clear_req = 1'b0;
        end
        check("no_ready_in_clear", 32'(stray), 32'd0);
        @(negedge clk);
        check("held_cpu_after_clear", 32'(bus.cpu_ready), 32'd1);
        push_exp(12'd20, 16'h0755, 1'b0);
        @(posedge clk) #1 bus.cpu_valid = 1'b0;
        wait_drain(10);

        // Reset in the middle of a clear at address 700
        @(posedge clk) #1 bus.clear_req = 1'b1;
        push_clear();
        @(posedge clk) #1 bus.clear_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (bus.vram_we && bus.vram_addr == 12'd700) found = 1'b1;
        end
        check("reach_addr_700", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_we",   32'(bus.vram_we),    32'd0);
        check("midrst_busy", 32'(bus.clear_busy), 32'd1);
        check("midrst_addr", 32'(bus.vram_addr),  32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        push_clear();
        @(posedge clk) #1 rst = 1'b1;
        wait_drain(2100);
        check("busy_after_reclear", 32'(bus.clear_busy), 32'd0);

        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
